// File: rtl/mesh_term_tx.sv
// rtl/mesh_term_tx.sv - terminal-side mesh router transmit agent with FWFT packet FIFO
// Optional statistics counters enabled by defining MESH_TX_STATS_EN.
module mesh_term_tx #(
  parameter int         pckg_sz    = 40,
  parameter logic [7:0] broadcast  = {8{1'b1}},
  parameter int         fifo_depth = 4,
  parameter int         id_r       = 0,
  parameter int         id_c       = 0,
  parameter int         rows       = 4,
  parameter int         columns    = 4
) (
  input  logic                            clk_i,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic                            wr_bcast,
  input  logic [3:0]                      wr_row,
  input  logic [3:0]                      wr_col,
  input  logic                            wr_mode,
  input  logic [pckg_sz-18:0]             wr_payload,
  output logic                            full,
  output logic [$clog2(fifo_depth+1)-1:0] count,
  output logic [pckg_sz-1:0]              data_out_i_in,
  output logic                            pndng_i_in,
  input  logic                            popin,
  output logic                            err_ovf,
  output logic                            err_dest,
  output logic                            err_udf
`ifdef MESH_TX_STATS_EN
  ,
  output logic [31:0]                     tx_cnt,
  output logic [15:0]                     drop_cnt
`endif
);

  localparam int pw = $clog2(fifo_depth);
  localparam int cw = $clog2(fifo_depth+1);

  // Configuration sanity: the terminal must sit inside the mesh it talks to.
  if (fifo_depth < 2 || id_r >= rows || id_c >= columns) begin : g_bad_cfg
    $error("mesh_term_tx: invalid configuration");
  end

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [pw-1:0]      wr_ptr;
  logic [pw-1:0]      rd_ptr;
  logic [cw-1:0]      count_next;
  logic               pop_ok;
  logic               dest_ok;
  logic               accept;
  logic [7:0]         dest;
  logic [pckg_sz-1:0] pkt;

  function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
    return (p == pw'(fifo_depth-1)) ? '0 : p + pw'(1);
  endfunction

  assign pndng_i_in    = (count != '0);
  assign pop_ok        = popin & pndng_i_in;
  assign dest_ok       = wr_bcast | ((32'(wr_row) < rows) & (32'(wr_col) < columns));
  assign accept        = wr_en & dest_ok & (~full | pop_ok);
  assign dest          = wr_bcast ? broadcast : {wr_row, wr_col};
  assign pkt           = {8'h00, dest, wr_mode, wr_payload};
  assign data_out_i_in = pndng_i_in ? mem[rd_ptr] : '0;

  always_comb begin
    count_next = count;
    if (accept && !pop_ok)
      count_next = count + cw'(1);
    else if (pop_ok && !accept)
      count_next = count - cw'(1);
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      err_ovf  <= 1'b0;
      err_dest <= 1'b0;
      err_udf  <= 1'b0;
      for (int i = 0; i < fifo_depth; i++)
        mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= pkt;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok)
        rd_ptr <= ptr_inc(rd_ptr);
      count    <= count_next;
      full     <= (count_next == cw'(fifo_depth));
      // A bad destination is reported instead of overflow for the same write.
      err_dest <= err_dest | (wr_en & ~dest_ok);
      err_ovf  <= err_ovf | (wr_en & dest_ok & full & ~pop_ok);
      err_udf  <= err_udf | (popin & ~pndng_i_in);
    end
  end

`ifdef MESH_TX_STATS_EN
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      tx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop_ok && tx_cnt != '1)
        tx_cnt <= tx_cnt + 32'd1;
      if (wr_en && !accept && drop_cnt != '1)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
